// File: rtl/disp_arb_pkg.sv
// Shared types and helpers for the display-sharing arbiter.
package disp_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [6:0] BLANK_ALL = 7'b1111111;

  // First pending index at or after ptr, wrapping modulo nreq; returns ptr if nothing pends.
  function automatic logic [2:0] next_rr(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned nreq);
    logic [2:0] idx;
    next_rr = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (i < int'(nreq)) begin
        idx = 3'((int'(ptr) + i) % int'(nreq));
        if (req[idx]) next_rr = idx;
      end
    end
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Free-running prescaler producing a one-cycle tick each time the count wraps.
module disp_tick_gen #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt_q;

  assign o_tick = (cnt_q == CW'(PRESCALE - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (o_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/disp_share_arb.sv
// Round-robin arbiter sharing one 4-digit hex display with a minimum per-grant dwell.
// Define DISP_ARB_PREEMPT_EN to let a rising request 0 preempt any other grant.
module disp_share_arb
  import disp_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned HOLD_TICKS = 200
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic [16*NREQ-1:0] i_value,
  output logic [NREQ-1:0]    o_gnt,
  output logic [3:0]         o_digit0,
  output logic [3:0]         o_digit1,
  output logic [3:0]         o_digit2,
  output logic [3:0]         o_digit3,
  output logic               o_blank,
  output logic               o_busy
);

  localparam int unsigned DW = $clog2(HOLD_TICKS + 1);

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    rr_q, rr_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [15:0]   digits_q, digits_d;
  logic          tick;
  logic [7:0]    req, req_others;
  logic          expired, preempt;
  logic [15:0]   slice [8];

  disp_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_tick(tick)
  );

  for (genvar k = 0; k < 8; k++) begin : g_slice
    if (k < NREQ) begin : g_used
      assign slice[k] = i_value[16*k +: 16];
    end else begin : g_pad
      assign slice[k] = '0;
    end
  end

  assign req        = 8'(i_req);
  assign req_others = req & ~(8'b1 << idx_q);
  assign expired    = (dwell_q == DW'(HOLD_TICKS));

`ifdef DISP_ARB_PREEMPT_EN
  logic req0_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) req0_q <= 1'b0;
    else       req0_q <= i_req[0];
  end
  assign preempt = (state_q == HOLD) && (idx_q != 3'd0) && i_req[0] && !req0_q;
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    dwell_d = dwell_q;
    unique case (state_q)
      IDLE: begin
        dwell_d = '0;
        if (|req) begin
          state_d = HOLD;
          idx_d   = next_rr(req, rr_q, NREQ);
          rr_d    = 3'((int'(idx_d) + 1) % int'(NREQ));
        end
      end
      HOLD: begin
        if (tick && !expired) dwell_d = dwell_q + DW'(1);
        if (preempt) begin
          // Preemptive grant leaves rr_q alone so rotation resumes where it was.
          idx_d   = 3'd0;
          dwell_d = '0;
        end else if (!req[idx_q] || (expired && |req_others)) begin
          if (|req_others) begin
            idx_d   = next_rr(req_others, rr_q, NREQ);
            rr_d    = 3'((int'(idx_d) + 1) % int'(NREQ));
            dwell_d = '0;
          end else begin
            state_d = IDLE;
            dwell_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    digits_d = (state_d == HOLD) ? slice[idx_d] : digits_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_q     <= '0;
      dwell_q  <= '0;
      digits_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      dwell_q  <= dwell_d;
      digits_q <= digits_d;
    end
  end

  always_comb begin
    o_gnt = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      o_gnt[k] = (state_q == HOLD) && (idx_q == 3'(k));
    end
  end

  assign o_busy   = (state_q == HOLD);
  assign o_blank  = !o_busy;
  assign o_digit0 = digits_q[15:12];
  assign o_digit1 = digits_q[11:8];
  assign o_digit2 = digits_q[7:4];
  assign o_digit3 = digits_q[3:0];

endmodule

// File: doc/disp_share_arb.md
Name: disp_share_arb

Overview:
- Arbiter sharing the single 4-digit hex display between up to NREQ requesters (debug counters, status, UI).
- Grants one requester at a time, round-robin, with a minimum dwell time so every value stays readable.
- Drives the four nibble inputs of the digit-multiplex driver, plus a blank flag for when no requester is granted.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PRESCALE, 50000, i_clk cycles per dwell tick (>=2).
- HOLD_TICKS, 200, minimum ticks a grant is held before it may rotate (>=1).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_req  in  NREQ  per-requester request, level.
- i_value  in  16*NREQ  requester k value in bits [16k+15:16k]; nibble 0 is the leftmost digit.
- o_gnt  out  NREQ  one-hot grant, all-zero when idle.
- o_digit0..o_digit3  out  4 each  nibbles of the granted value.
- o_blank  out  1  high when no grant; downstream forces segments off.
- o_busy  out  1  high while a grant is active.

Behaviour:
- Reset: o_gnt=0, o_digit*=0, o_blank=1, o_busy=0, state=IDLE, rr pointer=0, tick counter=0, dwell counter=0.
- Tick: free-running counter 0..PRESCALE-1; a one-cycle tick pulses when it wraps. Reset holds it at 0. The counter runs in every state.
- IDLE:
  - If any i_req is high at cycle t, select the first requester at or after rr pointer (modulo NREQ).
  - At t+1: o_gnt is one-hot, o_busy=1, o_blank=0, state=HOLD, dwell=0.
- HOLD:
  - dwell increments on each tick and saturates at HOLD_TICKS.
  - Dwell expires when dwell==HOLD_TICKS.
- Transitions out of HOLD, evaluated each cycle:
  - Granted req dropped: release regardless of dwell.
    - If another req is pending, switch directly to the next requester after the current one at the next cycle, with dwell reset.
    - Otherwise go to IDLE at the next cycle: o_gnt=0, o_blank=1, o_busy=0.
  - Dwell expired and another req pending: switch to the next pending requester after the current one; dwell reset.
  - Dwell expired and only the current req pending: keep the grant indefinitely with dwell saturated; rotate as soon as another req rises.
- rr pointer: loaded with granted index + 1 (mod NREQ) on every new grant.
- Data path:
  - While granted, o_digit* are registered from the granted slice each cycle, so live updates appear 1 cycle later.
  - On the grant cycle, o_digit* already carry the new requester's value.
  - In IDLE, o_digit* hold their last values (o_blank covers them).
- Simultaneous events: release and a new request in the same cycle use the normal rotation order. A tick on the switch cycle is not counted toward the new grant.
- o_gnt is never multi-hot and never changes more than once per cycle.
- Reset mid-grant returns everything to reset values on the next edge.

Optional Feature:
- Macro: DISP_ARB_PREEMPT_EN.
- Defined: requester 0 is urgent. A rising i_req[0] while another requester is granted preempts it at the next cycle regardless of dwell; dwell is reset. The rr pointer is not updated by a preemptive grant, so rotation resumes where it left off after requester 0 releases.
- Undefined: requester 0 is ordinary round-robin.

Decomposition:
- Package disp_arb_pkg holds:
  - state encoding: IDLE=1'b0, HOLD=1'b1;
  - the BLANK_ALL=7'b1111111 segment constant;
  - a function next_rr(req, ptr) returning the first pending index at or after ptr.
- Sub-module disp_tick_gen(PRESCALE) produces the tick pulse; reused by other display timing.

Test Plan (PRESCALE=4, HOLD_TICKS=3, so dwell = 12 cycles):
- Reset with i_req=4'b0000 -> o_gnt=0, o_blank=1, o_busy=0 for 20 cycles.
- i_req=4'b0100, i_value[47:32]=16'h1234 at t -> at t+1 o_gnt=4'b0100, o_digit0..3=1,2,3,4, o_blank=0.
- i_req=4'b0101 held -> grants alternate 0001, 0100, 0001..., each lasting exactly 12 cycles once the tick phase is aligned.
- Grant on req 2, drop i_req[2] after 3 cycles with i_req[1]=1 -> o_gnt=4'b0010 next cycle, no dwell wait.
- Single requester held 100 cycles -> o_gnt stays constant. Raise i_req[3] -> o_gnt=4'b1000 on the next cycle, since dwell is already saturated.
- With DISP_ARB_PREEMPT_EN: req 2 granted at dwell 1, raise i_req[0] -> o_gnt=4'b0001 next cycle. After req 0 drops, rotation continues from 3.
